display_pattern_gen: RTL and testbench



---
 rtl/display_pkg.sv | 18 +
 rtl/display_pixel_counter.sv | 81 ++++++++
 rtl/display_pattern_gen.sv | 103 ++++++++++
 tb/tb_display_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: types and constants shared by the colour-bar pattern generator.
package display_pkg;

  localparam int RGB_W = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Bar colours left to right, {R,G,B}: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [RGB_W-1:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/display_pixel_counter.sv
// display_pixel_counter: raster position of the beat currently presented.
// x/y walk the active frame; the bar index steps every H_ACTIVE/8 pixels,
// timed by a bar-pixel counter so no divider is needed. All counters wrap
// to zero after the last pixel, so they rest at the frame origin between
// frames.
module display_pixel_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance_i,
  output logic [2:0] bar_nxt_o,
  output logic       first_pixel_o,
  output logic       last_x_o,
  output logic       last_y_o,
  output logic       last_pixel_o
);

  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int X_W     = $clog2(H_ACTIVE);
  localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int P_W     = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0]     bar_q, bar_d;
  logic [P_W-1:0] bpix_q, bpix_d;
  logic           last_bpix;

  assign last_x_o      = (x_q == X_W'(H_ACTIVE - 1));
  assign last_y_o      = (y_q == Y_W'(V_ACTIVE - 1));
  assign last_bpix     = (bpix_q == P_W'(BAR_LEN - 1));
  assign last_pixel_o  = last_x_o & last_y_o;
  assign first_pixel_o = (x_q == '0) && (y_q == '0);
  assign bar_nxt_o     = bar_d;

  // Next raster position: hold unless a beat transfers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    x_d    = x_q;
    y_d    = y_q;
    bar_d  = bar_q;
    bpix_d = bpix_q;
    if (advance_i) begin
      if (last_x_o) begin
        x_d    = '0;
        bar_d  = '0;
        bpix_d = '0;
        y_d    = last_y_o ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
        if (last_bpix) begin
          bpix_d = '0;
          bar_d  = bar_q + 3'd1;
        end else begin
          bpix_d = bpix_q + P_W'(1);
        end
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      bar_q  <= '0;
      bpix_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      bar_q  <= bar_d;
      bpix_q <= bpix_d;
    end
  end

endmodule

// File: rtl/display_pattern_gen.sv
// display_pattern_gen: streams whole frames of an 8-bar RGB888 colour-bar
// pattern on an Avalon-ST source while en is high. Streaming only stops on
// a frame boundary, so the sink never sees a truncated frame.
// Optional build macro DISPLAY_PATTERN_FRAME_CNT_EN adds a 16-bit count of
// completed frames (frame_cnt) with a synchronous clear (frame_cnt_clr).
module display_pattern_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE = 640,  // multiple of 8, at least 8
  parameter int V_ACTIVE = 480   // at least 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             src_ready,
  output logic             src_valid,
  output logic [RGB_W-1:0] src_data,
  output logic             src_sop,
  output logic             src_eop,
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
  input  logic             frame_cnt_clr,
  output logic [15:0]      frame_cnt,
`endif
  output logic             busy
);

  state_e           state_q, state_d;
  logic [RGB_W-1:0] data_q, data_d;
  logic [2:0]       bar_nxt;
  logic             first_pixel;
  logic             last_x;
  logic             last_y;
  logic             last_pixel;
  logic             xfer;
  logic             frame_done;

  // A beat moves whenever we present one and the sink accepts it.
  assign xfer       = (state_q == ACTIVE) && src_ready;
  assign frame_done = xfer & last_x & last_y;

  display_pixel_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pixel_counter (
    .clk           (clk),
    .reset_n       (reset_n),
    .advance_i     (xfer),
    .bar_nxt_o     (bar_nxt),
    .first_pixel_o (first_pixel),
    .last_x_o      (last_x),
    .last_y_o      (last_y),
    .last_pixel_o  (last_pixel)
  );

  // Next state and next pixel; en is only looked at in IDLE and on the
  // final beat of a frame, so dropping it mid-frame has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = ACTIVE;
      ACTIVE:  if (frame_done && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_d = (state_d == ACTIVE) ? BAR_COLORS[bar_nxt] : '0;
  end

  // State and registered pixel data; data only changes with the beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Counters sit on the beat being presented, so the markers are stable
  // through stalls and fall straight to zero with the state on reset.
  assign busy      = (state_q == ACTIVE);
  assign src_valid = busy;
  assign src_data  = data_q;
  assign src_sop   = busy & first_pixel;
  assign src_eop   = busy & last_pixel;

`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_cnt_clr) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_display_pattern_gen.sv
// Bench for display_pattern_gen with a 16x4 frame (64 beats per frame).
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_display_pattern_gen;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int FRAME = H * V;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        src_ready;
  logic        src_valid;
  logic [23:0] src_data;
  logic        src_sop;
  logic        src_eop;
  logic        busy;
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
  logic        frame_cnt_clr;
  logic [15:0] frame_cnt;
`endif

  int n_cmp;
  int n_err;
  int exp_beat;
  int xfer_cnt;
  int sop_cnt;
  bit eop_xfer;

  display_pattern_gen #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .src_ready     (src_ready),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
    .frame_cnt_clr (frame_cnt_clr),
    .frame_cnt     (frame_cnt),
`endif
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected colour of beat b within a frame: 2 pixels per bar at H=16.
  function automatic logic [23:0] color_of(input int b);
    int bar;
    bar = (b % H) / 2;
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Called at a falling edge: check the presented beat against the model,
  // drive ready for the coming rising edge and advance the model on a transfer.
  task automatic step(input bit rdy);
    if (src_valid) begin
      check("data", src_data, color_of(exp_beat));
      check("sop", src_sop, exp_beat == 0);
      check("eop", src_eop, exp_beat == FRAME - 1);
    end else if (exp_beat != 0) begin
      check("valid_midframe", src_valid, 1);
    end
    src_ready = rdy;
    eop_xfer  = 1'b0;
    if (src_valid && rdy) begin
      xfer_cnt++;
      if (exp_beat == 0) sop_cnt++;
      eop_xfer = (exp_beat == FRAME - 1);
      exp_beat = (exp_beat + 1) % FRAME;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    n_cmp     = 0;
    n_err     = 0;
    exp_beat  = 0;
    xfer_cnt  = 0;
    sop_cnt   = 0;
    eop_xfer  = 1'b0;
    reset_n   = 1'b0;
    en        = 1'b0;
    src_ready = 1'b0;
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
    frame_cnt_clr = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid", src_valid, 0);
    check("rst_sop", src_sop, 0);
    check("rst_eop", src_eop, 0);
    check("rst_data", src_data, 0);
    check("rst_busy", busy, 0);
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
    check("rst_frame_cnt", frame_cnt, 0);
`endif
    reset_n = 1'b1;

    // Idle with en low: nothing is presented.
    repeat (3) begin
      @(negedge clk);
      check("idle_valid", src_valid, 0);
      step(1'b1);
    end

    // en rises: valid, sop and busy one cycle later.
    en = 1'b1;
    step(1'b1);
    @(negedge clk);
    check("start_valid", src_valid, 1);
    check("start_sop", src_sop, 1);
    check("start_busy", busy, 1);
    check("start_data", src_data, 24'hFFFFFF);
    xfer_cnt = 0;
    sop_cnt  = 0;
    step(1'b1);

    // Three back-to-back frames with ready always high.
    for (int c = 0; c < 400 && xfer_cnt < 3 * FRAME; c++) begin
      @(negedge clk);
      check("busy_3f", busy, 1);
      check("valid_3f", src_valid, 1);
      step(1'b1);
    end
    check("beats_3f", xfer_cnt, 3 * FRAME);
    check("sops_3f", sop_cnt, 3);
    @(negedge clk);
    check("frame4_sop", src_sop, 1);
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
    check("frame_cnt_3", frame_cnt, 3);
`endif
    step(1'b1);

    // en dropped mid-frame: the frame still completes, then idle.
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (exp_beat == 20) en = 1'b0;
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
      frame_cnt_clr = src_valid && (exp_beat == FRAME - 1);
`endif
      step(1'b1);
      done = eop_xfer;
    end
    check("drop_eop_seen", done, 1);
    @(negedge clk);
    check("drop_valid", src_valid, 0);
    check("drop_busy", busy, 0);
`ifdef DISPLAY_PATTERN_FRAME_CNT_EN
    check("frame_cnt_clr", frame_cnt, 0);
    frame_cnt_clr = 1'b0;
`endif
    step(1'b1);
    repeat (4) begin
      @(negedge clk);
      check("after_drop_valid", src_valid, 0);
      check("after_drop_sop", src_sop, 0);
      step(1'b1);
    end

    // Random backpressure: same beat sequence, stable through stalls.
    en       = 1'b1;
    xfer_cnt = 0;
    done     = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (xfer_cnt >= 10) en = 1'b0;
      step(1'($urandom_range(0, 1)));
      done = eop_xfer;
    end
    check("rand_beats", xfer_cnt, FRAME);
    @(negedge clk);
    check("rand_end_valid", src_valid, 0);
    step(1'b1);

    // One-cycle en pulse in IDLE starts exactly one full frame.
    @(negedge clk);
    en = 1'b1;
    step(1'b1);
    @(negedge clk);
    en       = 1'b0;
    xfer_cnt = 0;
    step(1'b1);
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      step(1'($urandom_range(0, 1)));
      done = eop_xfer;
    end
    check("pulse_beats", xfer_cnt, FRAME);
    @(negedge clk);
    check("pulse_end_valid", src_valid, 0);
    check("pulse_end_busy", busy, 0);
    step(1'b1);

    // Asynchronous reset at beat 30, then restart from the frame origin.
    en = 1'b1;
    for (int c = 0; c < 100 && exp_beat != 30; c++) begin
      @(negedge clk);
      step(1'b1);
    end
    check("reached_beat30", exp_beat, 30);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", src_valid, 0);
    check("arst_sop", src_sop, 0);
    check("arst_eop", src_eop, 0);
    check("arst_data", src_data, 0);
    check("arst_busy", busy, 0);
    exp_beat = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_valid", src_valid, 1);
    check("restart_sop", src_sop, 1);
    check("restart_data", src_data, 24'hFFFFFF);
    step(1'b1);
    en   = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      step(1'b1);
      done = eop_xfer;
    end
    check("restart_frame_done", done, 1);
    @(negedge clk);
    check("final_valid", src_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
